// File: rtl/pst_pkg.sv
// Shared definitions for the PST convergence controller: state encoding, datapath width, EMA step.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package pst_pkg;

    localparam int PST_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LEARN     = 2'd1,
        ST_CONVERGED = 2'd2,
        ST_SURPRISE  = 2'd3
    } pst_state_t;

    // One EMA step: avg + (din - avg) / 2^shift, arranged so that it never leaves 0..255.
    function automatic logic [PST_W-1:0] ema_next(input logic [PST_W-1:0] avg,
                                                   input logic [PST_W-1:0] din,
                                                   input int unsigned      shift);
        return avg - (avg >> shift) + (din >> shift);
    endfunction

endpackage

// File: rtl/pst_ema_filter.sv
// Exponential moving average of din, alpha = 1/2^SHIFT, reset/clear value 255.
// Latency: avg reflects a qualified din one clock after en.
// Backpressure: none; en qualifies each input, clear overrides en.
// Ports: clk, rst_n (async active-low), clear (force avg to 255), en (take din), din, avg.
module pst_ema_filter
    import pst_pkg::*;
#(
    parameter int SHIFT = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             en,
    input  logic [PST_W-1:0] din,
    output logic [PST_W-1:0] avg
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            avg <= 8'd255;
        end else if (clear) begin
            avg <= 8'd255;
        end else if (en) begin
            avg <= ema_next(avg, din, SHIFT);
        end
    end

endmodule

// File: rtl/pst_convergence_ctrl.sv
// Freezes L3 of a predictive hierarchy once the averaged L2 error stays low; unfreezes on surprise.
// Latency: state/avg update one clock after the sampling cycle_start; l3_freeze follows state directly.
// Backpressure: none; inputs are sampled only at gamma-cycle boundaries in which L1 fired.
// Ports: clk, rst_n (async active-low), cycle_start, enable, fired_L1, error_L2, error_L3 in;
//        l3_freeze, state, avg_err_L2, surprise_pulse, surprise_count out.
// Build option: define PST_CONV_STATS_EN to include the saturating surprise counter,
//        otherwise surprise_count is tied to zero.
module pst_convergence_ctrl
    import pst_pkg::*;
#(
    parameter logic [7:0] CONV_THRESH     = 8'd8,
    parameter logic [7:0] CONV_CYCLES     = 8'd8,
    parameter logic [7:0] SURPRISE_THRESH = 8'd64,
    parameter logic [7:0] HOLD_CYCLES     = 8'd16,
    parameter int         AVG_SHIFT       = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cycle_start,
    input  logic             enable,
    input  logic             fired_L1,
    input  logic [PST_W-1:0] error_L2,
    input  logic [PST_W-1:0] error_L3,
    output logic             l3_freeze,
    output logic [1:0]       state,
    output logic [PST_W-1:0] avg_err_L2,
    output logic             surprise_pulse,
    output logic [PST_W-1:0] surprise_count
);

    pst_state_t       state_q, state_d;
    logic [PST_W-1:0] streak_q, streak_d;
    logic [PST_W-1:0] hold_q, hold_d;
    logic             pulse_q, pulse_d;
    logic             fired_seen_q;
    logic             sample;
    logic             missed;
    logic [PST_W-1:0] avg_upd;

    // A boundary only counts if L1 fired somewhere in the cycle that just ended.
    assign sample  = cycle_start & enable & fired_seen_q;
    assign missed  = cycle_start & ~fired_seen_q;
    // Convergence is judged on the average including the current sample.
    assign avg_upd = ema_next(avg_err_L2, error_L2, AVG_SHIFT);

    pst_ema_filter #(.SHIFT(AVG_SHIFT)) u_ema (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (~enable),
        .en    (sample),
        .din   (error_L2),
        .avg   (avg_err_L2)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            streak_q     <= '0;
            hold_q       <= '0;
            pulse_q      <= 1'b0;
            fired_seen_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            streak_q     <= streak_d;
            hold_q       <= hold_d;
            pulse_q      <= pulse_d;
            // A fire on the boundary clock belongs to the cycle that is starting.
            fired_seen_q <= cycle_start ? fired_L1 : (fired_seen_q | fired_L1);
        end
    end

    always_comb begin
        state_d  = state_q;
        streak_d = streak_q;
        hold_d   = hold_q;
        pulse_d  = 1'b0;
        if (!enable) begin
            state_d  = ST_IDLE;
            streak_d = '0;
            hold_d   = '0;
        end else begin
            if (missed) begin
                streak_d = '0;
            end
            case (state_q)
                ST_IDLE: state_d = ST_LEARN;
                ST_LEARN: begin
                    if (sample) begin
                        if (avg_upd < CONV_THRESH) begin
                            streak_d = (streak_q >= CONV_CYCLES) ? CONV_CYCLES : streak_q + 8'd1;
                        end else begin
                            streak_d = '0;
                        end
                        if (streak_d >= CONV_CYCLES) begin
                            state_d = ST_CONVERGED;
                        end
                    end
                end
                ST_CONVERGED: begin
                    if (sample && (error_L2 > SURPRISE_THRESH || error_L3 > SURPRISE_THRESH)) begin
                        state_d = ST_SURPRISE;
                        pulse_d = 1'b1;
                        hold_d  = HOLD_CYCLES;
                    end
                end
                ST_SURPRISE: begin
                    if (sample) begin
                        hold_d = (hold_q != '0) ? hold_q - 8'd1 : '0;
                        if (hold_d == '0) begin
                            state_d  = ST_LEARN;
                            streak_d = '0;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

`ifdef PST_CONV_STATS_EN
    logic [PST_W-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (pulse_d && count_q != 8'd255) begin
            count_q <= count_q + 8'd1;
        end
    end

    assign surprise_count = count_q;
`else
    assign surprise_count = 8'd0;
`endif

    assign state          = state_q;
    assign l3_freeze      = (state_q == ST_CONVERGED);
    assign surprise_pulse = pulse_q;

endmodule

// File: doc/pst_convergence_ctrl.md
PST_CONVERGENCE_CTRL -- requirements
Module: pst_convergence_ctrl

Interface
REQ-001 SHALL have parameter CONV_THRESH, default 8'd8: averaged L2 error below which a sample counts as converged.
REQ-002 SHALL have parameter CONV_CYCLES, default 8'd8: consecutive converged samples required to freeze L3.
REQ-003 SHALL have parameter SURPRISE_THRESH, default 8'd64: raw L2 error above which a frozen hierarchy unfreezes.
REQ-004 SHALL have parameter HOLD_CYCLES, default 8'd16: samples spent in SURPRISE before returning to LEARN.
REQ-005 SHALL have parameter AVG_SHIFT, default 3: EMA shift (alpha = 1/2^AVG_SHIFT), legal range 1..7.
REQ-006 SHALL have port clk, input, 1, sole clock.
REQ-007 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port cycle_start, input, 1, one-clock pulse marking each gamma-cycle boundary.
REQ-009 SHALL have port enable, input, 1, controller run enable.
REQ-010 SHALL have port fired_L1, input, 1, L1 fired flag of the hierarchy.
REQ-011 SHALL have port error_L2, input, 8, L2 prediction-error magnitude.
REQ-012 SHALL have port error_L3, input, 8, L3 prediction-error magnitude.
REQ-013 SHALL have port l3_freeze, output, 1, drives the hierarchy's L3 freeze input.
REQ-014 SHALL have port state, output, 2, IDLE=0, LEARN=1, CONVERGED=2, SURPRISE=3.
REQ-015 SHALL have port avg_err_L2, output, 8, EMA of sampled error_L2.
REQ-016 SHALL have port surprise_pulse, output, 1, one-clock pulse on CONVERGED->SURPRISE.
REQ-017 SHALL have port surprise_count, output, 8, saturating surprise counter (see Configuration).

Function
REQ-018 SHALL set an internal fired_seen flag when fired_L1=1 and clear it on cycle_start; fired_L1 coincident with cycle_start belongs to the new cycle.
REQ-019 SHALL define a sample event as cycle_start=1 and enable=1 and fired_seen=1; error_L2 and error_L3 are read at that edge.
REQ-020 On each sample event, avg_err_L2 SHALL update to avg - (avg>>AVG_SHIFT) + (error_L2>>AVG_SHIFT), 8-bit unsigned; the result never exceeds 255, so no saturation logic is required.
REQ-021 cycle_start with fired_seen=0 (missed cycle) SHALL leave avg unchanged and clear the converged streak.
REQ-022 IDLE: l3_freeze=0; moves to LEARN on the clock after enable=1.
REQ-023 LEARN: on a sample, the updated avg < CONV_THRESH increments the streak, otherwise the streak clears; streak reaching CONV_CYCLES moves to CONVERGED with l3_freeze=1 on the same edge.
REQ-024 CONVERGED: l3_freeze=1; a sample with error_L2 > SURPRISE_THRESH or error_L3 > SURPRISE_THRESH moves to SURPRISE, pulses surprise_pulse, drops l3_freeze, and loads hold=HOLD_CYCLES.
REQ-025 SURPRISE: l3_freeze=0; each sample decrements hold; reaching 0 moves to LEARN with the streak cleared.
REQ-026 enable=0 in any state SHALL force IDLE on the next clock, set avg=8'd255, and clear streak and hold; surprise_count is retained.
REQ-027 The streak counter SHALL saturate at CONV_CYCLES; hold SHALL never wrap below 0.

Reset
REQ-028 rst_n=0 SHALL asynchronously set state=IDLE, l3_freeze=0, avg_err_L2=8'd255, surprise_pulse=0, surprise_count=0, streak=0, hold=0, fired_seen=0.

Configuration
REQ-029 Macro PST_CONV_STATS_EN SHALL be defined: surprise_count increments on each surprise_pulse and saturates at 255; not defined: the counter logic is compiled out and surprise_count is tied to 8'd0 (the port remains present).

Structure
REQ-030 Package pst_pkg SHALL hold the 2-bit state encoding and the phase/error width constant (8).
REQ-031 The EMA update SHALL be a sub-module, pst_ema_filter (ports: clk, rst_n, clear, en, din, avg).

Verification
REQ-032 Reset mid-LEARN -> all outputs at REQ-028 values in the same cycle, without waiting for clk.
REQ-033 enable=1, fired every cycle, error_L2=0 -> avg: 224, 196, 172 ... reaches 7 at sample 31; state=CONVERGED and l3_freeze=1 after sample 38.
REQ-034 In CONVERGED, one sample with error_L2=100 -> surprise_pulse for 1 clock, l3_freeze=0, state=SURPRISE; back to LEARN after 16 further samples.
REQ-035 In LEARN at streak 7, a cycle with no fired_L1 -> streak cleared, avg unchanged, no freeze.
REQ-036 In CONVERGED, drop enable -> IDLE next clock, l3_freeze=0, avg=255.
REQ-037 With PST_CONV_STATS_EN, 300 surprises -> surprise_count=255; without the macro -> surprise_count stays 0.
